// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - ISA widths and opcodes shared by fetch and decode
// Contents: INSTR_W/ADDR_W widths, opcode_e (OP_HALT, OP_NOP), is_halt() helper.
package fetch_stage_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  typedef enum logic [4:0] {
    OP_HALT = 5'b00000,
    OP_NOP  = 5'b00001
  } opcode_e;

  // Opcode lives in the top five bits of every instruction word.
  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: 5] == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - show-ahead FIFO buffering {instr, pc} between fetch and decode
// Ports: clk, rst (sync, active-high); push/din write; pop consumes dout (head, zero latency);
//        flush empties the FIFO and wins over push; empty, full, count report occupancy.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty  = (r_count == '0);
  assign full   = (r_count == CW'(DEPTH));
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push & !full & !flush;
  assign w_pop  = pop & !empty & !flush;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, in-order imem requests, response FIFO, redirect/HALT
// Ports: clk, rst (sync, active-high)
//        imem_req_valid/imem_req_addr/imem_req_ready   : request channel (addr = current PC)
//        imem_resp_valid/imem_resp_data                : in-order response words
//        redirect_valid/redirect_pc                    : taken branch/jump from execute
//        dec_ready, instr_valid/instruction/pc_out/pc_plus2 : decode channel
//        halted                                        : HALT consumed, fetch frozen until rst
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               dec_ready,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  pc_plus2,
  output logic               halted
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = INSTR_W + ADDR_W;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_resp_pc;
  logic [CW-1:0]     r_inflight;
  logic [CW-1:0]     r_drop_cnt;
  logic              r_halted;

  logic              w_req_fire;
  logic              w_redirect;
  logic              w_push;
  logic              w_pop;
  logic              w_halt_pop;
  logic              w_flush;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic [CW-1:0]     w_fifo_count;
  logic [CW-1:0]     w_inflight_next;
  logic [CW:0]       w_occupancy;
  logic [FW-1:0]     w_fifo_dout;

  // Requests in flight plus words buffered never exceed DEPTH, so every
  // returning response is guaranteed a FIFO slot.
  assign w_occupancy    = {1'b0, r_inflight} + {1'b0, w_fifo_count};
  assign imem_req_valid = !rst & !r_halted & !redirect_valid & (w_occupancy < (CW+1)'(DEPTH));
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid & imem_req_ready;

  assign w_redirect  = redirect_valid & !r_halted;
  assign instr_valid = !rst & !w_fifo_empty & !redirect_valid & !r_halted;
  assign w_pop       = instr_valid & dec_ready;
  assign w_halt_pop  = w_pop & is_halt(w_fifo_dout[FW-1 -: INSTR_W]);
  assign w_flush     = w_redirect | w_halt_pop;

  // Everything still outstanding after a flush is stale, including any
  // request that happens to handshake in the flush cycle itself.
  assign w_inflight_next = r_inflight + CW'(w_req_fire) - CW'(imem_resp_valid);
  assign w_push          = imem_resp_valid & (r_drop_cnt == '0) & !w_flush & !w_fifo_full;

  fetch_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .din   ({imem_resp_data, r_resp_pc}),
    .dout  (w_fifo_dout),
    .empty (w_fifo_empty),
    .full  (w_fifo_full),
    .count (w_fifo_count)
  );

  assign instruction = w_fifo_dout[FW-1 -: INSTR_W];
  assign pc_out      = w_fifo_dout[ADDR_W-1:0];
  assign pc_plus2    = pc_out + ADDR_W'(2);
  assign halted      = r_halted;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_inflight <= '0;
      r_drop_cnt <= '0;
      r_halted   <= 1'b0;
    end else begin
      r_inflight <= w_inflight_next;
      if (w_halt_pop) begin
        r_halted <= 1'b1;
      end
      if (w_flush) begin
        r_drop_cnt <= w_inflight_next;
      end else if (imem_resp_valid && r_drop_cnt != '0) begin
        r_drop_cnt <= r_drop_cnt - CW'(1);
      end
      if (w_redirect) begin
        r_pc      <= redirect_pc;
        r_resp_pc <= redirect_pc;
      end else begin
        if (w_req_fire) begin
          r_pc <= r_pc + ADDR_W'(2);
        end
        if (w_push) begin
          r_resp_pc <= r_resp_pc + ADDR_W'(2);
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic [15:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [15:0] imem_resp_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        dec_ready;
  logic        instr_valid;
  logic [15:0] instruction;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2;
  logic        halted;

  logic        w_rst;
  logic        w_req_valid;
  logic [15:0] w_req_addr;
  logic        w_resp_valid;
  logic [15:0] w_resp_data;
  logic        w_instr_valid;
  logic [15:0] w_instruction;
  logic [15:0] w_pc_out;
  logic [15:0] w_pc_plus2;
  logic        w_halted;

  fetch_stage #(.RESET_PC(16'h0000), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_ready(dec_ready), .instr_valid(instr_valid), .instruction(instruction),
    .pc_out(pc_out), .pc_plus2(pc_plus2), .halted(halted)
  );

  fetch_stage #(.RESET_PC(16'hFFFC), .DEPTH(DEPTH)) u_dut_wrap (
    .clk(clk), .rst(w_rst),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr), .imem_req_ready(1'b1),
    .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
    .redirect_valid(1'b0), .redirect_pc(16'h0000),
    .dec_ready(1'b1), .instr_valid(w_instr_valid), .instruction(w_instruction),
    .pc_out(w_pc_out), .pc_plus2(w_pc_plus2), .halted(w_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // stimulus knobs
  int lat_min, lat_max, p_ready, p_dec, p_redir;
  logic [15:0] halt_addr;
  bit          force_redir;
  logic [15:0] force_pc;

  // behavioural model state
  int          cycle;
  logic [15:0] exp_req_pc;
  logic [15:0] exp_dec_pc;
  bit          m_halted;
  logic [15:0] mq_addr[$];
  int          mq_due[$];
  bit          prev_redir;
  bit          hold_pending;
  logic [15:0] hold_pc;

  // observation records
  logic [15:0] rec_req[$];
  logic [15:0] rec_pop[$];
  logic [15:0] rec_p2[$];
  int          n_fire, n_pop, first_valid_cycle;
  bit          resp_redir_hit;
  bit          last_iv, last_halted;
  logic [15:0] last_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [15:0] qat(input logic [15:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 16'hxxxx;
  endfunction

  // Instruction memory image: distinct non-HALT words everywhere except halt_addr.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] w;
    if (a == halt_addr) return 16'h0000;
    w = 16'(a * 16'h9E37) ^ 16'h5A5A;
    if (w[15:11] == 5'b00000) w[15] = 1'b1;
    return w;
  endfunction

  task automatic clear_rec();
    rec_req.delete(); rec_pop.delete(); rec_p2.delete();
    n_fire = 0; n_pop = 0; first_valid_cycle = -1; resp_redir_hit = 1'b0;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
      #1;
      chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      if (i > 0) chk("rst_halted", {31'b0, halted}, 32'd0);
    end
    mq_addr.delete(); mq_due.delete();
    cycle = 0; exp_req_pc = 16'h0000; exp_dec_pc = 16'h0000; m_halted = 1'b0;
    prev_redir = 1'b0; hold_pending = 1'b0; force_redir = 1'b0;
    clear_rec();
  endtask

  task automatic step();
    bit fire, pop, was_halted;
    @(negedge clk);
    rst = 1'b0;
    imem_req_ready = ($urandom_range(0, 99) < p_ready);
    dec_ready      = ($urandom_range(0, 99) < p_dec);
    redirect_valid = 1'b0;
    if (force_redir) begin
      redirect_valid = 1'b1; redirect_pc = force_pc; force_redir = 1'b0;
    end else if (!prev_redir && $urandom_range(0, 999) < p_redir) begin
      redirect_valid = 1'b1; redirect_pc = 16'($urandom) & 16'hFFFE;
    end
    prev_redir = redirect_valid;
    imem_resp_valid = 1'b0; imem_resp_data = '0;
    if (mq_addr.size() > 0 && mq_due[0] <= cycle) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq_addr[0]);
      void'(mq_addr.pop_front()); void'(mq_due.pop_front());
    end
    #1;
    chk("halted", {31'b0, halted}, {31'b0, m_halted});
    if (m_halted) begin
      chk("halted_no_req", {31'b0, imem_req_valid}, 32'd0);
      chk("halted_no_instr", {31'b0, instr_valid}, 32'd0);
    end
    if (imem_req_valid) chk("req_addr", {16'b0, imem_req_addr}, {16'b0, exp_req_pc});
    if (redirect_valid && !m_halted) begin
      chk("redir_no_instr", {31'b0, instr_valid}, 32'd0);
      chk("redir_no_req", {31'b0, imem_req_valid}, 32'd0);
    end
    if (hold_pending && !redirect_valid) begin
      chk("hold_valid", {31'b0, instr_valid}, 32'd1);
      chk("hold_pc", {16'b0, pc_out}, {16'b0, hold_pc});
    end
    if (instr_valid) begin
      chk("dec_pc", {16'b0, pc_out}, {16'b0, exp_dec_pc});
      chk("dec_instr", {16'b0, instruction}, {16'b0, mem_word(exp_dec_pc)});
      chk("dec_pc_plus2", {16'b0, pc_plus2}, {16'b0, 16'(exp_dec_pc + 16'd2)});
      if (first_valid_cycle < 0) first_valid_cycle = cycle;
    end
    if (mq_addr.size() + int'(imem_resp_valid) > DEPTH) begin
      chk("outstanding_le_depth", mq_addr.size() + int'(imem_resp_valid), DEPTH);
    end
    // advance the model across the coming posedge
    fire = imem_req_valid & imem_req_ready;
    pop  = instr_valid & dec_ready;
    was_halted = m_halted;
    if (fire) begin
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(cycle + $urandom_range(lat_min, lat_max));
      rec_req.push_back(imem_req_addr);
      n_fire++;
      exp_req_pc = exp_req_pc + 16'd2;
    end
    if (pop) begin
      rec_pop.push_back(pc_out); rec_p2.push_back(pc_plus2);
      n_pop++;
      if (exp_dec_pc == halt_addr) m_halted = 1'b1;
      exp_dec_pc = exp_dec_pc + 16'd2;
    end
    if (redirect_valid && !was_halted) begin
      exp_req_pc = redirect_pc; exp_dec_pc = redirect_pc;
    end
    hold_pending   = instr_valid & !dec_ready;
    hold_pc        = pc_out;
    last_iv        = instr_valid; last_pc = pc_out; last_halted = halted;
    resp_redir_hit = resp_redir_hit | (redirect_valid & imem_resp_valid);
    cycle++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] wq_req[$];
    logic [15:0] wq_pop[$];
    logic [15:0] wq_p2[$];
    bit          w_pend;
    logic [15:0] w_pend_addr;
    int          guard;

    rst = 1'b1; w_rst = 1'b1;
    imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = '0;
    redirect_valid = 0; redirect_pc = '0; dec_ready = 0;
    w_resp_valid = 0; w_resp_data = '0;
    halt_addr = 16'hFFFF; force_pc = '0;

    // 1: streaming, 1-cycle memory
    do_reset(2);
    lat_min = 1; lat_max = 1; p_ready = 100; p_dec = 100; p_redir = 0;
    run(12);
    chk("t1_req0", {16'b0, qat(rec_req, 0)}, 32'h0000);
    chk("t1_req1", {16'b0, qat(rec_req, 1)}, 32'h0002);
    chk("t1_req2", {16'b0, qat(rec_req, 2)}, 32'h0004);
    chk("t1_pop0", {16'b0, qat(rec_pop, 0)}, 32'h0000);
    chk("t1_pop2", {16'b0, qat(rec_pop, 2)}, 32'h0004);
    chk("t1_p2_1", {16'b0, qat(rec_p2, 1)}, 32'h0004);
    chk("t1_first_valid_cycle", first_valid_cycle, 2);

    // 2: decode stalled from the start
    do_reset(2);
    p_dec = 0;
    run(15);
    chk("t2_stall_reqs", n_fire, DEPTH);
    chk("t2_stall_valid", {31'b0, last_iv}, 32'd1);
    chk("t2_stall_pc", {16'b0, last_pc}, 32'h0000);
    p_dec = 100;
    run(15);
    chk("t2_pop0", {16'b0, qat(rec_pop, 0)}, 32'h0000);
    chk("t2_pop1", {16'b0, qat(rec_pop, 1)}, 32'h0002);
    chk("t2_pop2", {16'b0, qat(rec_pop, 2)}, 32'h0004);

    // 3: redirect with two 3-cycle requests outstanding
    do_reset(2);
    lat_min = 3; lat_max = 3;
    guard = 0;
    while (mq_addr.size() < 2 && guard < 20) begin step(); guard++; end
    chk("t3_two_inflight", mq_addr.size(), 2);
    clear_rec();
    force_redir = 1'b1; force_pc = 16'h0040;
    run(20);
    chk("t3_req_after", {16'b0, qat(rec_req, 0)}, 32'h0040);
    chk("t3_pop_after", {16'b0, qat(rec_pop, 0)}, 32'h0040);

    // 4: redirect in the same cycle as a response
    do_reset(2);
    lat_min = 2; lat_max = 2;
    guard = 0;
    while (!(mq_addr.size() > 0 && mq_due[0] <= cycle) && guard < 20) begin step(); guard++; end
    clear_rec();
    force_redir = 1'b1; force_pc = 16'h0100;
    step();
    chk("t4_resp_redir_same", {31'b0, resp_redir_hit}, 32'd1);
    chk("t4_no_valid", {31'b0, last_iv}, 32'd0);
    run(20);
    chk("t4_pop_after", {16'b0, qat(rec_pop, 0)}, 32'h0100);

    // 5: HALT at 0x0006
    do_reset(2);
    lat_min = 1; lat_max = 1; halt_addr = 16'h0006;
    run(30);
    chk("t5_last_pop", {16'b0, qat(rec_pop, rec_pop.size() - 1)}, 32'h0006);
    chk("t5_halted", {31'b0, last_halted}, 32'd1);
    force_redir = 1'b1; force_pc = 16'h0200;
    run(10);
    chk("t5_still_halted", {31'b0, last_halted}, 32'd1);
    halt_addr = 16'hFFFF;
    do_reset(2);
    run(4);
    chk("t5_restart", {16'b0, qat(rec_req, 0)}, 32'h0000);

    // random soak
    do_reset(2);
    lat_min = 1; lat_max = 4; p_ready = 70; p_dec = 60; p_redir = 30;
    run(3000);
    chk("soak_progress", {31'b0, n_pop > 300}, 32'd1);

    // 6: RESET_PC = 0xFFFC wrap, separate instance
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); w_rst = 1'b1; w_resp_valid = 1'b0;
    end
    w_pend = 1'b0; w_pend_addr = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      w_rst = 1'b0;
      w_resp_valid = w_pend;
      w_resp_data  = mem_word(w_pend_addr);
      #1;
      if (w_req_valid) wq_req.push_back(w_req_addr);
      if (w_instr_valid) begin
        wq_pop.push_back(w_pc_out); wq_p2.push_back(w_pc_plus2);
        chk("t6_instr", {16'b0, w_instruction}, {16'b0, mem_word(w_pc_out)});
      end
      w_pend = w_req_valid; w_pend_addr = w_req_addr;
    end
    chk("t6_req0", {16'b0, qat(wq_req, 0)}, 32'hFFFC);
    chk("t6_req1", {16'b0, qat(wq_req, 1)}, 32'hFFFE);
    chk("t6_req2", {16'b0, qat(wq_req, 2)}, 32'h0000);
    chk("t6_pop0", {16'b0, qat(wq_pop, 0)}, 32'hFFFC);
    chk("t6_pop1", {16'b0, qat(wq_pop, 1)}, 32'hFFFE);
    chk("t6_p2_1", {16'b0, qat(wq_p2, 1)}, 32'h0000);
    chk("t6_not_halted", {31'b0, w_halted}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
